// File: rtl/apb_pwm_timer_mc.sv
// rtl/apb_pwm_timer_mc.sv - multi-channel APB timer/PWM peripheral with shadowed period/duty
//
// Purpose: NUM_CH independent CNT_W-bit counter channels, each producing a
// registered PWM output and a maskable wrap interrupt, configured over a
// zero-wait-state APB slave.
//
// Ports:
//   PCLK, PRESETn         clock (rising edge) and async active-low reset
//   PADDR/PSEL/PENABLE/
//   PWRITE/PWDATA         APB request
//   PREADY                tied 1
//   PRDATA, PSLVERR       combinational access-phase response
//   IRQ                   registered OR of enabled pending wrap bits
//   PWM[NUM_CH]           registered per-channel PWM outputs
//
// Register map (offset = PADDR[11:0]):
//   c*0x10 + 0x0  CTRL     {POL, IRQ_EN, GO_EN, MODE}
//   c*0x10 + 0x4  TOT_CNT
//   c*0x10 + 0x8  DUTY_CNT
//   c*0x10 + 0xC  CNT      read-only
//   0x100         IRQ_STAT write-1-to-clear

module apb_pwm_timer_mc #(
  parameter logic [11:0] BASE_ADR = 12'h44a,
  parameter int          ADR_W    = 32,
  parameter int          DAT_W    = 32,
  parameter int          NUM_CH   = 4,
  parameter int          CNT_W    = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [ADR_W-1:0]  PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [DAT_W-1:0]  PWDATA,
  output logic              PREADY,
  output logic [DAT_W-1:0]  PRDATA,
  output logic              PSLVERR,
  output logic              IRQ,
  output logic [NUM_CH-1:0] PWM
);

  // Per-channel programmable state
  logic [NUM_CH-1:0] mode;
  logic [NUM_CH-1:0] go_en;
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] pol;
  logic [CNT_W-1:0]  tot      [NUM_CH];
  logic [CNT_W-1:0]  duty     [NUM_CH];

  // Per-channel running state
  logic [CNT_W-1:0]  act_tot  [NUM_CH];
  logic [CNT_W-1:0]  act_duty [NUM_CH];
  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [NUM_CH-1:0] pend;

  // Address decode
  logic        acc;
  logic        hit;
  logic [11:0] off;
  logic        is_ch;
  logic        is_stat;
  logic [3:0]  ch_idx;
  logic [1:0]  reg_sel;
  logic        ch_ok;
  logic        valid;
  logic        wr_en;
  logic        rd_en;

  // Per-channel strobes
  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] wr_tot;
  logic [NUM_CH-1:0] wr_duty;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] stop_sw;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] w1c;

  logic [DAT_W-1:0]  rdata;
  logic              unused_bits;

  assign unused_bits = ^{PADDR, PWDATA};

  assign acc     = PSEL & PENABLE;
  assign hit     = (PADDR[ADR_W-1 -: 12] == BASE_ADR);
  assign off     = PADDR[11:0];
  assign is_ch   = (off[11:8] == 4'h0) && (off[1:0] == 2'b00);
  assign is_stat = (off == 12'h100);
  assign ch_idx  = off[7:4];
  assign reg_sel = off[3:2];
  assign ch_ok   = (32'(ch_idx) < NUM_CH);

  // CNT is read-only, so a write to it is treated like an unmapped access.
  assign valid   = hit && ((is_ch && ch_ok && !(PWRITE && reg_sel == 2'd3)) || is_stat);
  assign wr_en   = acc & PWRITE & valid;
  assign rd_en   = acc & ~PWRITE & valid;

  assign PREADY  = 1'b1;
  assign PSLVERR = acc & ~valid;
  assign PRDATA  = rdata;

  always_comb begin
    wr_ctrl = '0;
    wr_tot  = '0;
    wr_duty = '0;
    start   = '0;
    stop_sw = '0;
    wrap    = '0;
    w1c     = '0;
    if (wr_en && is_stat) begin
      w1c = PWDATA[NUM_CH-1:0];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en && is_ch && ch_idx == 4'(c)) begin
        case (reg_sel)
          2'd0:    wr_ctrl[c] = 1'b1;
          2'd1:    wr_tot[c]  = 1'b1;
          2'd2:    wr_duty[c] = 1'b1;
          default: ;
        endcase
      end
      start[c]   = wr_ctrl[c] & PWDATA[1] & ~go_en[c];
      // A software stop pre-empts a wrap on the same edge: no pend, cnt to 0.
      stop_sw[c] = wr_ctrl[c] & ~PWDATA[1];
      wrap[c]    = go_en[c] && (act_tot[c] != '0) &&
                   (cnt[c] == act_tot[c] - CNT_W'(1)) && !stop_sw[c];
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      if (is_stat) begin
        rdata[NUM_CH-1:0] = pend;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_idx == 4'(c)) begin
            case (reg_sel)
              2'd0:    rdata[3:0]       = {pol[c], irq_en[c], go_en[c], mode[c]};
              2'd1:    rdata[CNT_W-1:0] = tot[c];
              2'd2:    rdata[CNT_W-1:0] = duty[c];
              default: rdata[CNT_W-1:0] = cnt[c];
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mode   <= '0;
      go_en  <= '0;
      irq_en <= '0;
      pol    <= '0;
      pend   <= '0;
      PWM    <= '0;
      IRQ    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        tot[c]      <= '0;
        duty[c]     <= '0;
        act_tot[c]  <= '0;
        act_duty[c] <= '0;
        cnt[c]      <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        // Software CTRL write overrides the one-shot hardware clear.
        if (wr_ctrl[c]) begin
          mode[c]   <= PWDATA[0];
          go_en[c]  <= PWDATA[1];
          irq_en[c] <= PWDATA[2];
          pol[c]    <= PWDATA[3];
        end else if (wrap[c] && mode[c]) begin
          go_en[c]  <= 1'b0;
        end

        if (wr_tot[c])  tot[c]  <= PWDATA[CNT_W-1:0];
        if (wr_duty[c]) duty[c] <= PWDATA[CNT_W-1:0];

        if (start[c] || wrap[c]) begin
          act_tot[c]  <= tot[c];
          act_duty[c] <= duty[c];
        end

        if (!go_en[c] || stop_sw[c] || wrap[c]) begin
          cnt[c] <= '0;
        end else if (act_tot[c] != '0) begin
          cnt[c] <= cnt[c] + CNT_W'(1);
        end

        // act_tot==0 forces the inactive level; duty>=tot is naturally always active.
        PWM[c] <= (go_en[c] && (act_tot[c] != '0) && (cnt[c] < act_duty[c])) ^ pol[c];
      end

      // Hardware set wins over a simultaneous write-1-to-clear.
      pend <= (pend & ~w1c) | wrap;
      IRQ  <= |(pend & irq_en);
    end
  end

endmodule

// File: tb/tb_apb_pwm_timer_mc.sv
// tb/tb_apb_pwm_timer_mc.sv - directed self-checking bench for apb_pwm_timer_mc

module tb_apb_pwm_timer_mc;

  logic        PCLK;
  logic        PRESETn;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic        IRQ;
  logic [3:0]  PWM;

  int checks;
  int errors;

  apb_pwm_timer_mc dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR),
    .IRQ     (IRQ),
    .PWM     (PWM)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

  // Returns one time unit after the commit edge.
  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    data = PRDATA;
    err  = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL reset_prdata got %h exp 0", PRDATA); end
    checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL reset_pslverr got %b exp 0", PSLVERR); end
    checks++; if (PREADY !== 1'b1) begin errors++; $display("FAIL reset_pready got %b exp 1", PREADY); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", IRQ); end
    checks++; if (PWM !== 4'h0) begin errors++; $display("FAIL reset_pwm got %h exp 0", PWM); end
  endtask

  task automatic test_regs();
    logic        err;
    logic [31:0] d;
    logic [31:0] addrs [3];
    logic [31:0] vals  [3];
    addrs = '{32'h44a0_0010, 32'h44a0_0014, 32'h44a0_0018};
    vals  = '{32'd0, 32'd16384, 32'd7000};
    for (int i = 0; i < 3; i++) begin
      apb_write(addrs[i], vals[i], err);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL regs_wr_err%0d got %b exp 0", i, err); end
    end
    for (int i = 0; i < 3; i++) begin
      apb_read(addrs[i], d, err);
      checks++; if (d !== vals[i]) begin errors++; $display("FAIL regs_rd%0d got %0d exp %0d", i, d, vals[i]); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL regs_rd_err%0d got %b exp 0", i, err); end
    end
  endtask

  task automatic test_errors();
    logic        err;
    logic [31:0] d;
    apb_write(32'h44a0_000C, 32'h5, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_wr_cnt got %b exp 1", err); end
    apb_read(32'h44a0_000C, d, err);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL err_cnt_unchanged got %h exp 0", d); end
    apb_write(32'h44a0_0FF0, 32'h1, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_unmapped got %b exp 1", err); end
    apb_read(32'h5550_0000, d, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_nohit got %b exp 1", err); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL err_nohit_data got %h exp 0", d); end
    apb_read(32'h44a0_0040, d, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_badch got %b exp 1", err); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL err_badch_data got %h exp 0", d); end
  endtask

  task automatic run_pwm_ch0(input logic inv, input string tag);
    logic err;
    logic exp_pwm;
    int   bad;
    apb_write(32'h44a0_0000, inv ? 32'hA : 32'h2, err);
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge PCLK); #1;
      exp_pwm = ((i % 10) < 3) ^ inv;
      checks++;
      if (PWM[0] !== exp_pwm) begin
        errors++;
        if (bad < 4) $display("FAIL %s_pwm cycle %0d got %b exp %b", tag, i, PWM[0], exp_pwm);
        bad++;
      end
    end
    apb_write(32'h44a0_0000, inv ? 32'h8 : 32'h0, err);
    @(posedge PCLK); #1;
    checks++; if (PWM[0] !== inv) begin errors++; $display("FAIL %s_stopped got %b exp %b", tag, PWM[0], inv); end
  endtask

  task automatic test_pwm_continuous();
    logic err;
    apb_write(32'h44a0_0004, 32'd10, err);
    apb_write(32'h44a0_0008, 32'd3, err);
    run_pwm_ch0(1'b0, "cont");
    run_pwm_ch0(1'b1, "cont_pol");
    apb_write(32'h44a0_0000, 32'h0, err);
  endtask

  task automatic test_shadow();
    logic       err;
    logic       werr;
    logic [0:0] samp [36];
    logic       exp_pwm;
    int         bad;
    logic [31:0] d;
    apb_write(32'h44a0_0004, 32'd10, err);
    apb_write(32'h44a0_0000, 32'h2, err);
    fork
      begin
        for (int i = 0; i < 36; i++) begin
          @(posedge PCLK); #2;
          samp[i] = PWM[0];
        end
      end
      begin
        @(posedge PCLK);
        apb_write(32'h44a0_0004, 32'd20, werr);
      end
    join
    bad = 0;
    for (int i = 0; i < 36; i++) begin
      exp_pwm = (i < 10) ? (i < 3) : (((i - 10) % 20) < 3);
      checks++;
      if (samp[i] !== exp_pwm) begin
        errors++;
        if (bad < 4) $display("FAIL shadow_pwm cycle %0d got %b exp %b", i, samp[i], exp_pwm);
        bad++;
      end
    end
    apb_write(32'h44a0_0000, 32'h0, err);
    apb_write(32'h44a0_0100, 32'hF, err);
    apb_read(32'h44a0_0100, d, err);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL shadow_pend_clear got %h exp 0", d); end
  endtask

  task automatic test_oneshot_irq();
    logic        err;
    logic [31:0] d;
    apb_write(32'h44a0_0024, 32'd5, err);
    apb_write(32'h44a0_0028, 32'd2, err);
    apb_write(32'h44a0_0020, 32'h7, err);
    repeat (5) @(posedge PCLK);
    #1;
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL oneshot_irq_early got %b exp 0", IRQ); end
    @(posedge PCLK); #1;
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL oneshot_irq got %b exp 1", IRQ); end
    apb_read(32'h44a0_0020, d, err);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL oneshot_ctrl got %h exp 5", d); end
    apb_read(32'h44a0_002C, d, err);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oneshot_cnt got %h exp 0", d); end
    apb_read(32'h44a0_0100, d, err);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL oneshot_stat got %h exp 4", d); end
    apb_write(32'h44a0_0100, 32'h4, err);
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL w1c_irq_hold got %b exp 1", IRQ); end
    @(posedge PCLK); #1;
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL w1c_irq_drop got %b exp 0", IRQ); end
  endtask

  task automatic test_back_to_back();
    logic        err;
    logic [31:0] d;
    apb_write(32'h44a0_0034, 32'd1, err);
    apb_write(32'h44a0_0038, 32'd0, err);
    apb_write(32'h44a0_0030, 32'h2, err);
    apb_write(32'h44a0_0100, 32'h8, err);
    apb_read(32'h44a0_0100, d, err);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL w1c_vs_set got %h exp 8", d); end
    checks++; if (PWM[3] !== 1'b0) begin errors++; $display("FAIL tot1_duty0_pwm got %b exp 0", PWM[3]); end
    apb_read(32'h44a0_003C, d, err);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL tot1_cnt got %h exp 0", d); end
    apb_write(32'h44a0_0030, 32'h0, err);
    apb_write(32'h44a0_0100, 32'h8, err);
    apb_read(32'h44a0_0100, d, err);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL stop_clear got %h exp 0", d); end
  endtask

  task automatic test_edges();
    logic        err;
    logic [31:0] d;
    int          bad;
    apb_write(32'h44a0_0014, 32'd0, err);
    apb_write(32'h44a0_0018, 32'd5, err);
    apb_write(32'h44a0_0010, 32'hE, err);
    repeat (6) @(posedge PCLK);
    #1;
    checks++; if (PWM[1] !== 1'b1) begin errors++; $display("FAIL tot0_pwm got %b exp 1", PWM[1]); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL tot0_irq got %b exp 0", IRQ); end
    apb_read(32'h44a0_001C, d, err);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL tot0_cnt got %h exp 0", d); end
    apb_read(32'h44a0_0100, d, err);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL tot0_pend got %h exp 0", d); end
    apb_write(32'h44a0_0010, 32'h0, err);

    apb_write(32'h44a0_0004, 32'd10, err);
    apb_write(32'h44a0_0008, 32'd12, err);
    apb_write(32'h44a0_0000, 32'h6, err);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge PCLK); #1;
      checks++;
      if (PWM[0] !== 1'b1) begin
        errors++;
        if (bad < 4) $display("FAIL duty_ge_tot cycle %0d got %b exp 1", i, PWM[0]);
        bad++;
      end
    end
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL duty_ge_tot_irq got %b exp 1", IRQ); end

    #3;
    PRESETn = 1'b0;
    #1;
    checks++; if (PWM !== 4'h0) begin errors++; $display("FAIL rst_mid_pwm got %h exp 0", PWM); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL rst_mid_irq got %b exp 0", IRQ); end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    for (int r = 0; r < 5; r++) begin
      logic [31:0] a;
      a = (r == 4) ? 32'h44a0_0100 : (32'h44a0_0000 + 32'(r * 4));
      apb_read(a, d, err);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_reg%0d got %h exp 0", r, d); end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    PRESETn = 1'b0;
    PADDR   = '0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PWDATA  = '0;
    repeat (3) @(posedge PCLK);
    #1;
    test_reset();
    PRESETn = 1'b1;
    test_regs();
    test_errors();
    test_pwm_continuous();
    test_shadow();
    test_oneshot_irq();
    test_back_to_back();
    test_edges();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
